// File: rtl/qsfp_i2c_cmd_arb.sv
// Per-transaction arbiter between the QSFP poller and host CSR TFR streams into one I2C command sink.
// Optional watchdog/abort path enabled by the macro QSFP_ARB_WATCHDOG_EN.
module qsfp_i2c_cmd_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter bit          HOST_FIRST     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  poll_data,
    input  logic        poll_valid,
    output logic        poll_ready,
    input  logic [9:0]  host_data,
    input  logic        host_valid,
    output logic        host_ready,
    output logic [15:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        grant_poll,
    output logic        grant_host,
    output logic        proto_err,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, OWN_POLL, OWN_HOST, ABORT} state_t;

    state_t     state, state_nxt;
    logic       tie_host, tie_host_nxt;
    logic       abort_sent, abort_sent_nxt;
    logic       out_free, poll_start, host_start;
    logic       load, drop, abort_load;
    logic [9:0] load_word;

    assign out_free   = ~m_valid | m_ready;
    assign poll_start = poll_valid & poll_data[9];
    assign host_start = host_valid & host_data[9];
    assign grant_poll = (state == OWN_POLL);
    assign grant_host = (state == OWN_HOST);

`ifdef QSFP_ARB_WATCHDOG_EN
    localparam logic [23:0] WD_LAST = 24'(TIMEOUT_CYCLES - 1);
    logic [23:0] wd;
    logic        wd_hit;

    assign wd_hit = (grant_poll | grant_host) & ~load & (wd == WD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wd <= '0;
        else if ((grant_poll | grant_host) & ~load & ~wd_hit)
            wd <= wd + 24'd1;
        else
            wd <= '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) timeout_err <= 1'b0;
        else       timeout_err <= abort_load;
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt      = state;
        tie_host_nxt   = tie_host;
        abort_sent_nxt = abort_sent;
        poll_ready     = 1'b0;
        host_ready     = 1'b0;
        load           = 1'b0;
        load_word      = poll_data;
        drop           = 1'b0;
        abort_load     = 1'b0;
        unique case (state)
            IDLE: if (out_free) begin
                // Only a START/START collision is a tie; a stray non-START word is still taken and dropped.
                if (poll_start && host_start) begin
                    host_ready   = tie_host;
                    poll_ready   = ~tie_host;
                    tie_host_nxt = ~tie_host;
                end else begin
                    poll_ready = poll_valid;
                    host_ready = host_valid;
                end
                drop = (poll_ready & ~poll_data[9]) | (host_ready & ~host_data[9]);
                if (host_ready && host_data[9]) begin
                    load      = 1'b1;
                    load_word = host_data;
                    if (!host_data[8]) state_nxt = OWN_HOST;
                end else if (poll_ready && poll_data[9]) begin
                    load      = 1'b1;
                    load_word = poll_data;
                    if (!poll_data[8]) state_nxt = OWN_POLL;
                end
            end
            OWN_POLL: begin
                poll_ready = out_free;
                if (poll_valid && out_free) begin
                    load      = 1'b1;
                    load_word = poll_data;
                    if (poll_data[8]) state_nxt = IDLE;
                end
            end
            OWN_HOST: begin
                host_ready = out_free;
                if (host_valid && out_free) begin
                    load      = 1'b1;
                    load_word = host_data;
                    if (host_data[8]) state_nxt = IDLE;
                end
            end
            ABORT: begin
                if (!abort_sent) begin
                    if (out_free) begin
                        abort_load     = 1'b1;
                        abort_sent_nxt = 1'b1;
                    end
                end else if (m_ready) begin
                    state_nxt      = IDLE;
                    abort_sent_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef QSFP_ARB_WATCHDOG_EN
        if (wd_hit) state_nxt = ABORT;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tie_host   <= HOST_FIRST;
            abort_sent <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            tie_host   <= tie_host_nxt;
            abort_sent <= abort_sent_nxt;
            proto_err  <= drop;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= {6'b0, load_word};
        end else if (abort_load) begin
            m_valid <= 1'b1;
            m_data  <= 16'h0100;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end
endmodule
